// File: rtl/gt_refclk_obuf.sv
// gt_refclk_obuf: gated, divided reference clock driven out as a differential
// pair. Start and stop are glitch-free: the first rising edge follows a fixed
// warm-up, and every high pulse lasts exactly DIV_HALF cycles, even when the
// enable is withdrawn partway through one.
module gt_refclk_obuf #(
  parameter logic       REFCLK_EN_TX_PATH = 1'b1,
  parameter logic [4:0] REFCLK_ICNTL_TX   = 5'd0,
  parameter int         DIV_HALF          = 1,
  parameter int         START_DLY         = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic CEB,
  output logic O,
  output logic OB,
  output logic ACTIVE
);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(DIV_HALF - 1);
  localparam logic [7:0] DLY_INIT  = 8'(START_DLY);

  // Drive strength has no behavioural meaning here; keep it referenced.
  logic unused_icntl;
  assign unused_icntl = ^REFCLK_ICNTL_TX;

  state_t     state_q, state_d;
  logic [7:0] dly_cnt_q, dly_cnt_d;
  logic [7:0] half_cnt_q, half_cnt_d;
  logic       o_q, o_d;
  logic       ob_q, ob_d;
  logic       active_q, active_d;
  logic       ceb_meta_q, ceb_meta_d;
  logic       ceb_s_q, ceb_s_d;
  logic       half_last;

  assign half_last = (half_cnt_q == HALF_LAST);

  // Synchroniser inputs: CEB may arrive from another clock domain.
  always_comb begin
    ceb_meta_d = CEB;
    ceb_s_d    = ceb_meta_q;
  end

  // Next-state logic; O only changes at phase boundaries so no runt pulses.
  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    half_cnt_d = half_cnt_q;
    o_d        = o_q;
    unique case (state_q)
      S_OFF: begin
        o_d = 1'b0;
        if (!ceb_s_q && REFCLK_EN_TX_PATH) begin
          state_d   = S_WARMUP;
          dly_cnt_d = DLY_INIT;
        end
      end
      S_WARMUP: begin
        o_d = 1'b0;
        if (ceb_s_q) begin
          // Abort; the next enable restarts the full warm-up.
          state_d = S_OFF;
        end else if (dly_cnt_q == 8'd0) begin
          state_d    = S_RUN;
          o_d        = 1'b1;
          half_cnt_d = 8'd0;
        end else begin
          dly_cnt_d = dly_cnt_q - 8'd1;
        end
      end
      S_RUN: begin
        if (half_last) begin
          o_d        = ~o_q;
          half_cnt_d = 8'd0;
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
        if (ceb_s_q) begin
          if (!o_d) begin
            // Output lands low on this edge: safe to stop immediately.
            state_d    = S_OFF;
            half_cnt_d = 8'd0;
          end else begin
            // A high phase is in progress; let it run its full length.
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (half_last) begin
          o_d        = 1'b0;
          half_cnt_d = 8'd0;
          state_d    = S_OFF;
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_OFF;
        o_d     = 1'b0;
      end
    endcase
    ob_d     = ~o_d;
    active_d = (state_d == S_RUN);
  end

  // State registers with synchronous reset; reset wins even mid-high-phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_OFF;
      dly_cnt_q  <= 8'd0;
      half_cnt_q <= 8'd0;
      o_q        <= 1'b0;
      ob_q       <= 1'b1;
      active_q   <= 1'b0;
      ceb_meta_q <= 1'b1;
      ceb_s_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      half_cnt_q <= half_cnt_d;
      o_q        <= o_d;
      ob_q       <= ob_d;
      active_q   <= active_d;
      ceb_meta_q <= ceb_meta_d;
      ceb_s_q    <= ceb_s_d;
    end
  end

  assign O      = o_q;
  assign OB     = ob_q;
  assign ACTIVE = active_q;

endmodule
